tlb_csr_group: RTL and testbench

- Parametrised CSR group holding the TLB-interface registers TLBEHI, TLBELO0, TLBELO1, TLBIDX and ASID.
- Sits beside the CSR file, between the CSR-instruction write port, the TLB array (TLBRD/TLBSRCH results) and the exception unit.
- Resolves same-cycle update conflicts per register.
- Provides a wrap-around random index counter for TLBFILL.

---
 rtl/tlb_csr_pkg.sv | 68 ++++++
 rtl/tlb_csr_group_if.sv | 48 ++++
 rtl/tlb_fill_cnt.sv | 35 +++
 rtl/tlb_csr_group.sv | 168 ++++++++++++++++
 tb/tb_tlb_csr_group.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlb_csr_pkg
// Purpose  : Shared definitions for the TLB CSR group: register select codes,
//            field positions, writable-bit masks, the ELO field struct and
//            small helpers for masked CSR merges and ELO sanitising.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tlb_csr_pkg;

  // Register select codes on csr_addr; 5..7 are unmapped.
  localparam logic [2:0] C_ADDR_EHI  = 3'd0;
  localparam logic [2:0] C_ADDR_ELO0 = 3'd1;
  localparam logic [2:0] C_ADDR_ELO1 = 3'd2;
  localparam logic [2:0] C_ADDR_IDX  = 3'd3;
  localparam logic [2:0] C_ADDR_ASID = 3'd4;

  // Field positions
  localparam int C_EHI_VPPN_LSB = 13;
  localparam int C_IDX_PS_LSB   = 24;
  localparam int C_IDX_NE_BIT   = 31;
  localparam int C_ASID_W       = 10;

  // ASIDBITS is hard-wired and read-only.
  localparam logic [7:0] C_ASIDBITS = 8'd10;

  // Writable-bit masks for the fixed-layout registers.
  localparam logic [31:0] C_EHI_WMASK  = 32'hFFFF_E000;
  localparam logic [31:0] C_ASID_WMASK = 32'h0000_03FF;

  // ELO layout. The PPN slot spans bits 31:8; only [PALEN-5:8] is backed.
  typedef struct packed {
    logic [23:0] ppn;
    logic        rsv;
    logic        g;
    logic [1:0]  mat;
    logic [1:0]  plv;
    logic        d;
    logic        v;
  } elo_t;

  // TLBIDX writable bits: NE, PS and the low idx_w bits of Index.
  function automatic logic [31:0] idx_wmask(input int idx_w);
    return 32'h8000_0000 | 32'h3F00_0000 | ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Classic CSR masked merge.
  function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                         input logic [31:0] wdata,
                                         input logic [31:0] wmask);
    return (old_val & ~wmask) | (wdata & wmask);
  endfunction

  // Drops the reserved bit and the PPN bits above the physical address width.
  function automatic logic [31:0] elo_sanitize(input logic [31:0] raw,
                                               input int          palen);
    elo_t        f;
    logic [23:0] ppn_keep;
    ppn_keep = 24'((64'd1 << (palen - 12)) - 64'd1);
    f        = elo_t'(raw);
    f.rsv    = 1'b0;
    f.ppn    = f.ppn & ppn_keep;
    return 32'(f);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_csr_group_if.sv
`default_nettype none
// ============================================================================
// Module   : tlb_csr_group_if
// Purpose  : Bus bundle into the TLB CSR group: CSR-instruction write/read
//            port, TLBRD and TLBSRCH result ports and the exception commit.
// Modports : master - CSR/TLB/exception side (drives requests, reads rdata)
//            slave  - tlb_csr_group (consumes requests, drives csr_rdata)
// Revision : 1.0 - initial release
// ============================================================================
interface tlb_csr_group_if #(
  parameter  int TLB_NUM = 16,
  localparam int IDX_W   = $clog2(TLB_NUM)
);
  logic             csr_we;
  logic [2:0]       csr_addr;
  logic [31:0]      csr_wdata;
  logic [31:0]      csr_wmask;
  logic [31:0]      csr_rdata;
  logic             tlbrd_en;
  logic             tlbrd_e;
  logic [18:0]      tlbrd_vppn;
  logic [5:0]       tlbrd_ps;
  logic [9:0]       tlbrd_asid;
  logic [31:0]      tlbrd_elo0;
  logic [31:0]      tlbrd_elo1;
  logic             tlbsrch_en;
  logic             tlbsrch_hit;
  logic [IDX_W-1:0] tlbsrch_idx;
  logic             exc_vld;
  logic [18:0]      exc_vppn;

  modport master (
    output csr_we, csr_addr, csr_wdata, csr_wmask,
    output tlbrd_en, tlbrd_e, tlbrd_vppn, tlbrd_ps, tlbrd_asid, tlbrd_elo0, tlbrd_elo1,
    output tlbsrch_en, tlbsrch_hit, tlbsrch_idx,
    output exc_vld, exc_vppn,
    input  csr_rdata
  );

  modport slave (
    input  csr_we, csr_addr, csr_wdata, csr_wmask,
    input  tlbrd_en, tlbrd_e, tlbrd_vppn, tlbrd_ps, tlbrd_asid, tlbrd_elo0, tlbrd_elo1,
    input  tlbsrch_en, tlbsrch_hit, tlbsrch_idx,
    input  exc_vld, exc_vppn,
    output csr_rdata
  );
endinterface
`default_nettype wire

// File: rtl/tlb_fill_cnt.sv
`default_nettype none
// ============================================================================
// Module   : tlb_fill_cnt
// Purpose  : Free-running modulo-TLB_NUM counter used as the TLBFILL index.
//            TLB_NUM need not be a power of two, so the wrap is explicit.
// Ports    : clk, rst_n (async, active-low), cnt (current index)
// Revision : 1.0 - initial release
// ============================================================================
module tlb_fill_cnt #(
  parameter  int TLB_NUM = 16,
  localparam int IDX_W   = $clog2(TLB_NUM)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  output logic      [IDX_W-1:0] cnt
);

  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(TLB_NUM - 1);

  logic [IDX_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/tlb_csr_group.sv
`default_nettype none
// ============================================================================
// Module   : tlb_csr_group
// Purpose  : TLB-interface CSRs (TLBEHI, TLBELO0, TLBELO1, TLBIDX, ASID) with
//            per-register update priority exc > TLBRD > TLBSRCH > CSR write,
//            plus the wrapping TLBFILL random index.
// Ports    : clk, rst_n (async, active-low)
//            bus      - tlb_csr_group_if.slave (CSR port, TLBRD/TLBSRCH, exc)
//            fill_idx - TLBFILL index
//            tlbehi, tlbelo0, tlbelo1, tlbidx, asid - register images
// Options  : TLB_CSR_RDATA_REG_EN - registered csr_rdata showing the
//            post-update register contents (write-then-read forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module tlb_csr_group
  import tlb_csr_pkg::*;
#(
  parameter  int TLB_NUM = 16,
  parameter  int PALEN   = 32,
  localparam int IDX_W   = $clog2(TLB_NUM)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  tlb_csr_group_if.slave        bus,
  output logic      [IDX_W-1:0] fill_idx,
  output logic      [31:0]      tlbehi,
  output logic      [31:0]      tlbelo0,
  output logic      [31:0]      tlbelo1,
  output logic      [31:0]      tlbidx,
  output logic      [31:0]      asid
);

  localparam logic [31:0] C_IDX_WMASK = idx_wmask(IDX_W);

  logic [31:0]         r_ehi, r_elo0, r_elo1, r_idx;
  logic [C_ASID_W-1:0] r_asid;

  logic [31:0]         w_ehi_nxt, w_elo0_nxt, w_elo1_nxt, w_idx_nxt;
  logic [C_ASID_W-1:0] w_asid_nxt;
  logic [31:0]         w_asid_img, w_asid_merge;
  logic                w_we_ehi, w_we_elo0, w_we_elo1, w_we_idx, w_we_asid;

  function automatic logic [31:0] asid_image(input logic [C_ASID_W-1:0] a);
    return {8'd0, C_ASIDBITS, 6'd0, a};
  endfunction

  function automatic logic [31:0] rd_mux(input logic [2:0]  addr,
                                         input logic [31:0] ehi,
                                         input logic [31:0] elo0,
                                         input logic [31:0] elo1,
                                         input logic [31:0] idx,
                                         input logic [31:0] asid_img);
    case (addr)
      C_ADDR_EHI:  return ehi;
      C_ADDR_ELO0: return elo0;
      C_ADDR_ELO1: return elo1;
      C_ADDR_IDX:  return idx;
      C_ADDR_ASID: return asid_img;
      default:     return 32'd0;
    endcase
  endfunction

  assign w_we_ehi  = bus.csr_we && (bus.csr_addr == C_ADDR_EHI);
  assign w_we_elo0 = bus.csr_we && (bus.csr_addr == C_ADDR_ELO0);
  assign w_we_elo1 = bus.csr_we && (bus.csr_addr == C_ADDR_ELO1);
  assign w_we_idx  = bus.csr_we && (bus.csr_addr == C_ADDR_IDX);
  assign w_we_asid = bus.csr_we && (bus.csr_addr == C_ADDR_ASID);

  assign w_asid_img   = asid_image(r_asid);
  assign w_asid_merge = wmerge(w_asid_img, bus.csr_wdata, bus.csr_wmask) & C_ASID_WMASK;

  // Each register resolves its own winner, so a lower-priority source still
  // lands on registers the higher-priority source does not touch.
  always_comb begin
    w_ehi_nxt  = r_ehi;
    w_elo0_nxt = r_elo0;
    w_elo1_nxt = r_elo1;
    w_idx_nxt  = r_idx;
    w_asid_nxt = r_asid;

    if (bus.exc_vld) begin
      w_ehi_nxt = {bus.exc_vppn, 13'd0};
    end else if (bus.tlbrd_en) begin
      w_ehi_nxt = bus.tlbrd_e ? {bus.tlbrd_vppn, 13'd0} : 32'd0;
    end else if (w_we_ehi) begin
      w_ehi_nxt = wmerge(r_ehi, bus.csr_wdata, bus.csr_wmask) & C_EHI_WMASK;
    end

    if (bus.tlbrd_en) begin
      w_elo0_nxt = bus.tlbrd_e ? elo_sanitize(bus.tlbrd_elo0, PALEN) : 32'd0;
      w_elo1_nxt = bus.tlbrd_e ? elo_sanitize(bus.tlbrd_elo1, PALEN) : 32'd0;
    end else begin
      if (w_we_elo0) begin
        w_elo0_nxt = elo_sanitize(wmerge(r_elo0, bus.csr_wdata, bus.csr_wmask), PALEN);
      end
      if (w_we_elo1) begin
        w_elo1_nxt = elo_sanitize(wmerge(r_elo1, bus.csr_wdata, bus.csr_wmask), PALEN);
      end
    end

    // TLBRD owns TLBIDX outright (also over an illegal concurrent TLBSRCH);
    // it rewrites NE/PS and leaves Index in place.
    if (bus.tlbrd_en) begin
      w_idx_nxt = {~bus.tlbrd_e, 1'b0, (bus.tlbrd_e ? bus.tlbrd_ps : 6'd0), r_idx[23:0]};
    end else if (bus.tlbsrch_en) begin
      w_idx_nxt = bus.tlbsrch_hit ? {1'b0, r_idx[30:IDX_W], bus.tlbsrch_idx}
                                  : {1'b1, r_idx[30:0]};
    end else if (w_we_idx) begin
      w_idx_nxt = wmerge(r_idx, bus.csr_wdata, bus.csr_wmask) & C_IDX_WMASK;
    end

    if (bus.tlbrd_en) begin
      w_asid_nxt = bus.tlbrd_e ? bus.tlbrd_asid : '0;
    end else if (w_we_asid) begin
      w_asid_nxt = w_asid_merge[C_ASID_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ehi  <= '0;
      r_elo0 <= '0;
      r_elo1 <= '0;
      r_idx  <= '0;
      r_asid <= '0;
    end else begin
      r_ehi  <= w_ehi_nxt;
      r_elo0 <= w_elo0_nxt;
      r_elo1 <= w_elo1_nxt;
      r_idx  <= w_idx_nxt;
      r_asid <= w_asid_nxt;
    end
  end

`ifdef TLB_CSR_RDATA_REG_EN
  // Read from the next-state values so a same-cycle write is returned.
  logic [31:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= rd_mux(bus.csr_addr, w_ehi_nxt, w_elo0_nxt, w_elo1_nxt,
                        w_idx_nxt, asid_image(w_asid_nxt));
    end
  end

  assign bus.csr_rdata = r_rdata;
`else
  assign bus.csr_rdata = rd_mux(bus.csr_addr, r_ehi, r_elo0, r_elo1, r_idx, w_asid_img);
`endif

  tlb_fill_cnt #(
    .TLB_NUM (TLB_NUM)
  ) u_fill_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (fill_idx)
  );

  assign tlbehi  = r_ehi;
  assign tlbelo0 = r_elo0;
  assign tlbelo1 = r_elo1;
  assign tlbidx  = r_idx;
  assign asid    = w_asid_img;

endmodule
`default_nettype wire

// File: tb/tb_tlb_csr_group.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_csr_group
// Purpose  : Self-checking bench for tlb_csr_group (TLB_NUM=12, PALEN=32).
//            Field-level reference model built from the register rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_csr_group;

  localparam int TLB_NUM = 12;
  localparam int PALEN   = 32;
  localparam int IDX_W   = $clog2(TLB_NUM);
  // ELO backed bits: V,D,PLV,MAT,G in 6:0 and PPN in [PALEN-5:8].
  localparam logic [31:0] ELO_WR = 32'h0000_007F | ((32'd1 << (PALEN - 4)) - 32'd256);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [IDX_W-1:0] fill_idx;
  logic [31:0]      tlbehi, tlbelo0, tlbelo1, tlbidx, asid;

  int errors = 0;
  int checks = 0;

  // Reference model state, held as fields.
  logic [18:0]      m_vppn;
  logic [31:0]      m_elo0, m_elo1;
  logic [IDX_W-1:0] m_index;
  logic [5:0]       m_ps;
  logic             m_ne;
  logic [9:0]       m_asid;
  int               m_fill;
  logic [31:0]      m_rdq;

  tlb_csr_group_if #(.TLB_NUM(TLB_NUM)) bus ();

  tlb_csr_group #(.TLB_NUM(TLB_NUM), .PALEN(PALEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fill_idx (fill_idx),
    .tlbehi   (tlbehi),
    .tlbelo0  (tlbelo0),
    .tlbelo1  (tlbelo1),
    .tlbidx   (tlbidx),
    .asid     (asid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_img(input logic [2:0] a);
    case (a)
      3'd0:    return {m_vppn, 13'd0};
      3'd1:    return m_elo0;
      3'd2:    return m_elo1;
      3'd3:    return {m_ne, 1'b0, m_ps, 24'(m_index)};
      3'd4:    return {8'd0, 8'd10, 6'd0, m_asid};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [31:0] m);
    return (o & ~m) | (w & m);
  endfunction

  task automatic model_reset();
    m_vppn = '0; m_elo0 = '0; m_elo1 = '0; m_index = '0;
    m_ps = '0; m_ne = 1'b0; m_asid = '0; m_fill = 0; m_rdq = '0;
  endtask

  // Applies one clock edge worth of events to the model.
  task automatic model_update();
    logic [31:0] img;
    logic wr;
    wr = bus.csr_we;
    if (bus.exc_vld) m_vppn = bus.exc_vppn;
    else if (bus.tlbrd_en) m_vppn = bus.tlbrd_e ? bus.tlbrd_vppn : 19'd0;
    else if (wr && bus.csr_addr == 3'd0) begin
      img = merge(m_img(3'd0), bus.csr_wdata, bus.csr_wmask);
      m_vppn = img[31:13];
    end
    if (bus.tlbrd_en) begin
      m_elo0 = bus.tlbrd_e ? (bus.tlbrd_elo0 & ELO_WR) : 32'd0;
      m_elo1 = bus.tlbrd_e ? (bus.tlbrd_elo1 & ELO_WR) : 32'd0;
    end else if (wr && bus.csr_addr == 3'd1) m_elo0 = merge(m_elo0, bus.csr_wdata, bus.csr_wmask) & ELO_WR;
    else if (wr && bus.csr_addr == 3'd2) m_elo1 = merge(m_elo1, bus.csr_wdata, bus.csr_wmask) & ELO_WR;
    if (bus.tlbrd_en) begin
      m_ps = bus.tlbrd_e ? bus.tlbrd_ps : 6'd0;
      m_ne = !bus.tlbrd_e;
    end else if (bus.tlbsrch_en) begin
      if (bus.tlbsrch_hit) begin m_index = bus.tlbsrch_idx; m_ne = 1'b0; end
      else m_ne = 1'b1;
    end else if (wr && bus.csr_addr == 3'd3) begin
      img = merge(m_img(3'd3), bus.csr_wdata, bus.csr_wmask);
      m_index = img[IDX_W-1:0]; m_ps = img[29:24]; m_ne = img[31];
    end
    if (bus.tlbrd_en) m_asid = bus.tlbrd_e ? bus.tlbrd_asid : 10'd0;
    else if (wr && bus.csr_addr == 3'd4) begin
      img = merge(m_img(3'd4), bus.csr_wdata, bus.csr_wmask);
      m_asid = img[9:0];
    end
    m_fill = (m_fill + 1) % TLB_NUM;
    m_rdq  = m_img(bus.csr_addr);
  endtask

  task automatic clear_inputs();
    bus.csr_we = 0; bus.csr_addr = '0; bus.csr_wdata = '0; bus.csr_wmask = '0;
    bus.tlbrd_en = 0; bus.tlbrd_e = 0; bus.tlbrd_vppn = '0; bus.tlbrd_ps = '0;
    bus.tlbrd_asid = '0; bus.tlbrd_elo0 = '0; bus.tlbrd_elo1 = '0;
    bus.tlbsrch_en = 0; bus.tlbsrch_hit = 0; bus.tlbsrch_idx = '0;
    bus.exc_vld = 0; bus.exc_vppn = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    model_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (tlbehi !== 32'd0) begin errors++; $display("FAIL reset_ehi got=%h exp=%h", tlbehi, 32'd0); end
    checks++; if (tlbelo0 !== 32'd0) begin errors++; $display("FAIL reset_elo0 got=%h exp=%h", tlbelo0, 32'd0); end
    checks++; if (tlbelo1 !== 32'd0) begin errors++; $display("FAIL reset_elo1 got=%h exp=%h", tlbelo1, 32'd0); end
    checks++; if (tlbidx !== 32'd0) begin errors++; $display("FAIL reset_idx got=%h exp=%h", tlbidx, 32'd0); end
    checks++; if (asid !== 32'h000A_0000) begin errors++; $display("FAIL reset_asid got=%h exp=%h", asid, 32'h000A_0000); end
    checks++; if (fill_idx !== '0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_idx); end
    checks++; if (bus.csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.csr_rdata); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_csr_write();
    bus.csr_we = 1; bus.csr_addr = 3'd0; bus.csr_wdata = 32'hFFFF_FFFF; bus.csr_wmask = 32'h0000_E000;
    tick();
    checks++; if (tlbehi !== 32'h0000_E000) begin errors++; $display("FAIL csrxchg_ehi got=%h exp=%h", tlbehi, 32'h0000_E000); end
    bus.csr_addr = 3'd4;
`ifdef TLB_CSR_RDATA_REG_EN
    tick();
`else
    #1;
`endif
    checks++; if (bus.csr_rdata !== 32'h000A_0000) begin errors++; $display("FAIL rdata_asid got=%h exp=%h", bus.csr_rdata, 32'h000A_0000); end
    for (int i = 0; i < 30; i++) begin
      bus.csr_we = 1; bus.csr_addr = 3'($urandom_range(0, 7));
      bus.csr_wdata = $urandom; bus.csr_wmask = (i % 2 == 0) ? 32'hFFFF_FFFF : $urandom;
      tick();
      checks++;
      if ({tlbehi, tlbelo0, tlbelo1, tlbidx, asid} !== {m_img(0), m_img(1), m_img(2), m_img(3), m_img(4)}) begin
        errors++;
        $display("FAIL csr_rand_%0d got=%h %h %h %h %h exp=%h %h %h %h %h", i, tlbehi, tlbelo0, tlbelo1, tlbidx, asid,
                 m_img(0), m_img(1), m_img(2), m_img(3), m_img(4));
      end
    end
  endtask

  task automatic test_tlbrd();
    logic [31:0] e0;
    logic [IDX_W-1:0] keep;
    keep = m_index;
    e0 = $urandom;
    bus.tlbrd_en = 1; bus.tlbrd_e = 1; bus.tlbrd_vppn = 19'h12345; bus.tlbrd_ps = 6'h0C;
    bus.tlbrd_asid = 10'h3FF; bus.tlbrd_elo0 = e0; bus.tlbrd_elo1 = 32'hFFFF_FFFF;
    tick();
    checks++; if (tlbehi !== 32'h2468_A000) begin errors++; $display("FAIL tlbrd_ehi got=%h exp=%h", tlbehi, 32'h2468_A000); end
    checks++; if ({tlbidx[31], tlbidx[29:24]} !== 7'h0C) begin errors++; $display("FAIL tlbrd_ne_ps got=%h exp=%h", {tlbidx[31], tlbidx[29:24]}, 7'h0C); end
    checks++; if (asid[9:0] !== 10'h3FF) begin errors++; $display("FAIL tlbrd_asid got=%h exp=%h", asid[9:0], 10'h3FF); end
    checks++; if (tlbelo0 !== (e0 & ELO_WR)) begin errors++; $display("FAIL tlbrd_elo0 got=%h exp=%h", tlbelo0, e0 & ELO_WR); end
    checks++; if (tlbelo1 !== 32'h0FFF_FF7F) begin errors++; $display("FAIL tlbrd_elo1 got=%h exp=%h", tlbelo1, 32'h0FFF_FF7F); end
    checks++; if (tlbidx[IDX_W-1:0] !== keep) begin errors++; $display("FAIL tlbrd_keep_idx got=%h exp=%h", tlbidx[IDX_W-1:0], keep); end
    bus.tlbrd_en = 1; bus.tlbrd_e = 0; bus.tlbrd_vppn = 19'h7_0000; bus.tlbrd_ps = 6'h15;
    tick();
    checks++; if (tlbidx !== ({8'h80, 24'd0} | 32'(keep))) begin errors++; $display("FAIL tlbrd_miss_idx got=%h exp=%h", tlbidx, {8'h80, 24'd0} | 32'(keep)); end
    checks++; if ({tlbehi, tlbelo0, tlbelo1} !== 96'd0) begin errors++; $display("FAIL tlbrd_miss_clr got=%h %h %h exp=0", tlbehi, tlbelo0, tlbelo1); end
    checks++; if (asid !== 32'h000A_0000) begin errors++; $display("FAIL tlbrd_miss_asid got=%h exp=%h", asid, 32'h000A_0000); end
  endtask

  task automatic test_tlbsrch();
    bus.tlbsrch_en = 1; bus.tlbsrch_hit = 1; bus.tlbsrch_idx = IDX_W'(7);
    tick();
    checks++; if (tlbidx !== 32'h0000_0007) begin errors++; $display("FAIL srch_hit got=%h exp=%h", tlbidx, 32'h0000_0007); end
    bus.tlbsrch_en = 1; bus.tlbsrch_hit = 0; bus.tlbsrch_idx = IDX_W'(3);
    tick();
    checks++; if (tlbidx !== 32'h8000_0007) begin errors++; $display("FAIL srch_miss got=%h exp=%h", tlbidx, 32'h8000_0007); end
  endtask

  task automatic test_collision();
    bus.exc_vld = 1; bus.exc_vppn = 19'h7FFFF;
    bus.csr_we = 1; bus.csr_addr = 3'd0; bus.csr_wdata = 32'd0; bus.csr_wmask = 32'hFFFF_FFFF;
    bus.tlbrd_en = 1; bus.tlbrd_e = 1; bus.tlbrd_vppn = 19'd0; bus.tlbrd_elo0 = 32'h1234_5678;
    tick();
    checks++; if (tlbehi !== 32'hFFFF_E000) begin errors++; $display("FAIL coll_ehi got=%h exp=%h", tlbehi, 32'hFFFF_E000); end
    checks++; if (tlbelo0 !== 32'h0234_5678) begin errors++; $display("FAIL coll_elo0 got=%h exp=%h", tlbelo0, 32'h0234_5678); end
    bus.exc_vld = 1; bus.exc_vppn = 19'h00001;
    bus.csr_we = 1; bus.csr_addr = 3'd4; bus.csr_wdata = 32'hFFFF_0155; bus.csr_wmask = 32'hFFFF_FFFF;
    tick();
    checks++; if ({tlbehi, asid} !== {32'h0000_2000, 32'h000A_0155}) begin errors++; $display("FAIL coll_asid got=%h %h exp=%h %h", tlbehi, asid, 32'h0000_2000, 32'h000A_0155); end
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    for (int i = 0; i < 300; i++) begin
      bus.exc_vld     = ($urandom_range(0, 3) == 0);
      bus.exc_vppn    = 19'($urandom);
      bus.tlbrd_en    = ($urandom_range(0, 3) == 0);
      bus.tlbrd_e     = 1'($urandom_range(0, 1));
      bus.tlbrd_vppn  = 19'($urandom);
      bus.tlbrd_ps    = 6'($urandom);
      bus.tlbrd_asid  = 10'($urandom);
      bus.tlbrd_elo0  = $urandom;
      bus.tlbrd_elo1  = $urandom;
      bus.tlbsrch_en  = ($urandom_range(0, 3) == 0);
      bus.tlbsrch_hit = 1'($urandom_range(0, 1));
      bus.tlbsrch_idx = IDX_W'($urandom_range(0, TLB_NUM - 1));
      bus.csr_we      = 1'($urandom_range(0, 1));
      bus.csr_addr    = 3'($urandom_range(0, 7));
      bus.csr_wdata   = $urandom;
      bus.csr_wmask   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
`ifndef TLB_CSR_RDATA_REG_EN
      #1;
      exp_rd = m_img(bus.csr_addr);
      checks++; if (bus.csr_rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata_%0d got=%h exp=%h", i, bus.csr_rdata, exp_rd); end
`endif
      tick();
`ifdef TLB_CSR_RDATA_REG_EN
      exp_rd = m_rdq;
      checks++; if (bus.csr_rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata_%0d got=%h exp=%h", i, bus.csr_rdata, exp_rd); end
`endif
      checks++;
      if ({tlbehi, tlbelo0, tlbelo1, tlbidx, asid} !== {m_img(0), m_img(1), m_img(2), m_img(3), m_img(4)}) begin
        errors++;
        $display("FAIL rand_regs_%0d got=%h %h %h %h %h exp=%h %h %h %h %h", i, tlbehi, tlbelo0, tlbelo1, tlbidx, asid,
                 m_img(0), m_img(1), m_img(2), m_img(3), m_img(4));
      end
      checks++; if (fill_idx !== IDX_W'(m_fill)) begin errors++; $display("FAIL rand_fill_%0d got=%0d exp=%0d", i, fill_idx, m_fill); end
    end
  endtask

  task automatic test_fill_cnt();
    for (int i = 0; i < 40 && m_fill != 5; i++) tick();
    checks++; if (fill_idx !== IDX_W'(5)) begin errors++; $display("FAIL fill_pre got=%0d exp=5", fill_idx); end
    rst_n = 1'b0;
    #1;
    checks++; if (fill_idx !== '0) begin errors++; $display("FAIL fill_async_rst got=%0d exp=0", fill_idx); end
    checks++; if (tlbidx !== 32'd0) begin errors++; $display("FAIL regs_async_rst got=%h exp=0", tlbidx); end
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++; if (fill_idx !== IDX_W'(i)) begin errors++; $display("FAIL fill_count_%0d got=%0d exp=%0d", i, fill_idx, i); end
    end
    tick();
    checks++; if (fill_idx !== '0) begin errors++; $display("FAIL fill_wrap got=%0d exp=0", fill_idx); end
  endtask

  initial begin
    test_reset();
    test_csr_write();
    test_tlbrd();
    test_tlbsrch();
    test_collision();
    test_random();
    test_fill_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
